// File: rtl/range_seq_pkg.sv
// -----------------------------------------------------------------------------
// range_seq_pkg
// Shared definitions for the range frame sequencer: default sample width and
// frame depth, plus the sequencer state encoding.
// -----------------------------------------------------------------------------
package range_seq_pkg;

    localparam int RANGE_SEQ_WIDTH = 8;
    localparam int RANGE_SEQ_DEPTH = 16;

    // FILL : collecting a frame      FIRST/MID/LAST : replaying it
    // GAP  : idle cycle after finish DROP : discarding an oversized frame
    typedef enum logic [2:0] {
        FILL  = 3'd0,
        FIRST = 3'd1,
        MID   = 3'd2,
        LAST  = 3'd3,
        GAP   = 3'd4,
        DROP  = 3'd5
    } seq_state_e;

endpackage : range_seq_pkg

// File: rtl/range_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// range_frame_sequencer_if
// Valid/ready sample stream with end-of-frame flag feeding the sequencer.
//   in_data  : sample            (master -> slave)
//   in_valid : in_data valid     (master -> slave)
//   in_last  : last of frame     (master -> slave, qualified by in_valid)
//   in_ready : slave accepts     (slave  -> master)
// -----------------------------------------------------------------------------
interface range_frame_sequencer_if
    import range_seq_pkg::*;
#(
    parameter int WIDTH = RANGE_SEQ_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface : range_frame_sequencer_if

// File: rtl/range_seq_buffer.sv
// -----------------------------------------------------------------------------
// range_seq_buffer
// DEPTH x WIDTH frame storage. Synchronous write, asynchronous read, no reset
// (contents are don't-care until written).
//   clock     : write clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data (combinational)
// -----------------------------------------------------------------------------
module range_seq_buffer
    import range_seq_pkg::*;
#(
    parameter int WIDTH  = RANGE_SEQ_WIDTH,
    parameter int DEPTH  = RANGE_SEQ_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write port
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : range_seq_buffer

// File: rtl/range_frame_sequencer.sv
// -----------------------------------------------------------------------------
// range_frame_sequencer
// Buffers one complete frame from a valid/ready stream, then replays it as a
// contiguous go ... finish burst for the range finder, followed by one idle
// cycle. Frames longer than DEPTH are discarded and flagged with overflow.
//
// Ports:
//   clock     : single clock, posedge
//   reset     : synchronous, active-high
//   s_if      : sample stream (slave modport: in_data/in_valid/in_last/in_ready)
//   data_out  : sample to range finder
//   go        : first sample of burst
//   finish    : last sample of burst
//   busy      : frame in progress (partial fill, burst, gap or drop)
//   overflow  : one-cycle pulse when an oversized frame starts being dropped
//   frame_len : length of the last buffered frame (only with
//               RANGE_SEQ_LEN_OUT_EN defined)
//
// Build option: RANGE_SEQ_LEN_OUT_EN adds the frame_len output.
// Outputs are decoded from registered state only; no in_* -> output path.
// -----------------------------------------------------------------------------
module range_frame_sequencer
    import range_seq_pkg::*;
#(
    parameter int WIDTH = RANGE_SEQ_WIDTH,
    parameter int DEPTH = RANGE_SEQ_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    range_frame_sequencer_if.slave           s_if,
    output logic [WIDTH-1:0]                 data_out,
    output logic                             go,
    output logic                             finish,
    output logic                             busy,
`ifdef RANGE_SEQ_LEN_OUT_EN
    output logic [$clog2(DEPTH+1)-1:0]       frame_len,
`endif
    output logic                             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH+1);

    seq_state_e    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] len_q, len_d;
    logic          ovf_q, ovf_d;

    logic             ready_s;
    logic             accept_s;
    logic             full_s;
    logic             wr_en_s;
    logic             load_len_s;
    logic [AW-1:0]    rd_addr_s;
    logic [WIDTH-1:0] rd_data_s;

    assign ready_s    = (state_q == FILL) || (state_q == DROP);
    assign accept_s   = s_if.in_valid && ready_s;
    assign full_s     = (wr_ptr_q == PW'(DEPTH));
    assign wr_en_s    = (state_q == FILL) && accept_s && !full_s;
    assign load_len_s = wr_en_s && s_if.in_last;
    // LAST always shows the final stored sample; for a one-sample frame that
    // repeats mem[0] so the range finder sees zero range.
    assign rd_addr_s  = (state_q == LAST) ? AW'(len_q - PW'(1)) : rd_ptr_q;
    assign s_if.in_ready = ready_s;

    range_seq_buffer #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_buffer (
        .clock     (clock),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (s_if.in_data),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (rd_data_s)
    );

    // State, pointer and overflow registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and pointer update logic
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        ovf_d    = 1'b0;
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    if (full_s) begin
                        // Beat beyond capacity: drop it and the rest of the frame
                        ovf_d    = 1'b1;
                        wr_ptr_d = '0;
                        if (s_if.in_last) begin
                            state_d = FILL;
                        end else begin
                            state_d = DROP;
                        end
                    end else if (s_if.in_last) begin
                        len_d    = wr_ptr_q + PW'(1);
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        state_d  = FIRST;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DROP: begin
                if (accept_s && s_if.in_last) begin
                    state_d = FILL;
                end else begin
                    state_d = DROP;
                end
            end
            FIRST: begin
                if (len_q == PW'(1)) begin
                    rd_ptr_d = '0;
                    state_d  = LAST;
                end else if (len_q == PW'(2)) begin
                    rd_ptr_d = AW'(1);
                    state_d  = LAST;
                end else begin
                    rd_ptr_d = AW'(1);
                    state_d  = MID;
                end
            end
            MID: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                // Current MID sample is the second-to-last one
                if (PW'(rd_ptr_q) == (len_q - PW'(2))) begin
                    state_d = LAST;
                end else begin
                    state_d = MID;
                end
            end
            LAST: begin
                state_d = GAP;
            end
            GAP: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        data_out = '0;
        go       = 1'b0;
        finish   = 1'b0;
        case (state_q)
            FIRST: begin
                go       = 1'b1;
                data_out = rd_data_s;
            end
            MID: begin
                data_out = rd_data_s;
            end
            LAST: begin
                finish   = 1'b1;
                data_out = rd_data_s;
            end
            default: begin
                data_out = '0;
            end
        endcase
    end

    assign busy     = (state_q != FILL) || (wr_ptr_q != '0);
    assign overflow = ovf_q;

`ifdef RANGE_SEQ_LEN_OUT_EN
    logic [PW-1:0] frame_len_q;

    // Length of the most recently completed frame
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_len_q <= '0;
        end else if (load_len_s) begin
            frame_len_q <= wr_ptr_q + PW'(1);
        end else begin
            frame_len_q <= frame_len_q;
        end
    end

    assign frame_len = frame_len_q;
`else
    logic unused_load_len_s;
    assign unused_load_len_s = load_len_s;
`endif

endmodule : range_frame_sequencer

// File: tb/tb_range_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_range_frame_sequencer
// Directed, table-driven bench for range_frame_sequencer (WIDTH=8, DEPTH=16).
// -----------------------------------------------------------------------------
module tb_range_frame_sequencer;

    logic       clock;
    logic       reset;
    logic [7:0] data_out;
    logic       go;
    logic       finish;
    logic       busy;
    logic       overflow;
`ifdef RANGE_SEQ_LEN_OUT_EN
    logic [4:0] frame_len;
`endif

    range_frame_sequencer_if #(.WIDTH(8)) s_if ();

    range_frame_sequencer #(
        .WIDTH (8),
        .DEPTH (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .s_if      (s_if),
        .data_out  (data_out),
        .go        (go),
        .finish    (finish),
        .busy      (busy),
`ifdef RANGE_SEQ_LEN_OUT_EN
        .frame_len (frame_len),
`endif
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       rdy;
        logic       go;
        logic       fin;
        logic [7:0] dout;
        logic       busy;
        int         rng;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] frm [16];

    int mon_en  = 0;
    int go_seen = 0;

    always @(negedge clock) begin
        if (mon_en != 0 && go === 1'b1) go_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int d, input logic l, input logic rdy,
                       input logic g, input logic f, input int dout, input logic b,
                       input int rng);
        vec_t r;
        r.v = v; r.d = 8'(d); r.l = l; r.rdy = rdy; r.go = g; r.fin = f;
        r.dout = 8'(dout); r.busy = b; r.rng = rng;
        tbl.push_back(r);
    endtask

    // Drives frm[0..n-1] as a frame and checks the resulting burst, gap and
    // return to FILL; exp_rng is the hand-computed max-min of the frame.
    task automatic frame_check(input int n, input int exp_rng, input string tag);
        int bound;
        int mn;
        int mx;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            s_if.in_valid = 1'b1;
            s_if.in_data  = frm[i];
            s_if.in_last  = (i == n - 1);
            bound = 0;
            while (s_if.in_ready !== 1'b1 && bound < 50) begin
                @(posedge clock); #1;
                bound++;
            end
            if (bound >= 50) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        end
        @(posedge clock); #1;
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        @(negedge clock);
        chk({tag, "_go"}, 32'(go), 32'd1);
        chk({tag, "_first_data"}, 32'(data_out), 32'(frm[0]));
        chk({tag, "_first_fin"}, 32'(finish), 32'd0);
        mn = int'(data_out);
        mx = int'(data_out);
        for (int k = 1; k < ((n == 1) ? 2 : n); k++) begin
            @(negedge clock);
            chk($sformatf("%s_go_%0d", tag, k), 32'(go), 32'd0);
            chk($sformatf("%s_fin_%0d", tag, k), 32'(finish), 32'((k == n - 1) || (n == 1)));
            chk($sformatf("%s_data_%0d", tag, k), 32'(data_out), 32'(frm[(n == 1) ? 0 : k]));
            if (int'(data_out) < mn) mn = int'(data_out);
            if (int'(data_out) > mx) mx = int'(data_out);
        end
        chk({tag, "_range"}, 32'(mx - mn), 32'(exp_rng));
        @(negedge clock);
        chk({tag, "_gap_ready"}, 32'(s_if.in_ready), 32'd0);
        chk({tag, "_gap_go_fin"}, 32'({go, finish}), 32'd0);
        @(negedge clock);
        chk({tag, "_idle_ready"}, 32'(s_if.in_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int mn;
        int mx;
        int active;
        reset         = 1'b1;
        s_if.in_valid = 1'b0;
        s_if.in_data  = 8'd0;
        s_if.in_last  = 1'b0;

        // Frame 5,9,2,7
        add(1, 5, 0,   1, 0, 0, 0, 0, 0);
        add(1, 9, 0,   1, 0, 0, 0, 1, 0);
        add(1, 2, 0,   1, 0, 0, 0, 1, 0);
        add(1, 7, 1,   1, 0, 0, 0, 1, 0);
        add(0, 0, 0,   0, 1, 0, 5, 1, 0);
        add(0, 0, 0,   0, 0, 0, 9, 1, 0);
        add(0, 0, 0,   0, 0, 0, 2, 1, 0);
        add(0, 0, 0,   0, 0, 1, 7, 1, 7);
        add(0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 0, 0, 0);
        // Single-sample frame 42
        add(1, 42, 1,  1, 0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 1, 0, 42, 1, 0);
        add(0, 0, 0,   0, 0, 1, 42, 1, 0);
        add(0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 0, 0, 0);
        // Two-sample frame 3,200
        add(1, 3, 0,   1, 0, 0, 0, 0, 0);
        add(1, 200, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0,   0, 1, 0, 3, 1, 0);
        add(0, 0, 0,   0, 0, 1, 200, 1, 197);
        add(0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 0, 0, 0);
        // Back-to-back frames 1,2,3 then 10,20 with in_valid held high
        add(1, 1, 0,   1, 0, 0, 0, 0, 0);
        add(1, 2, 0,   1, 0, 0, 0, 1, 0);
        add(1, 3, 1,   1, 0, 0, 0, 1, 0);
        add(1, 10, 0,  0, 1, 0, 1, 1, 0);
        add(1, 10, 0,  0, 0, 0, 2, 1, 0);
        add(1, 10, 0,  0, 0, 1, 3, 1, 2);
        add(1, 10, 0,  0, 0, 0, 0, 1, 0);
        add(1, 10, 0,  1, 0, 0, 0, 0, 0);
        add(1, 20, 1,  1, 0, 0, 0, 1, 0);
        add(0, 0, 0,   0, 1, 0, 10, 1, 0);
        add(0, 0, 0,   0, 0, 1, 20, 1, 10);
        add(0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_ready", 32'(s_if.in_ready), 32'd1);
        chk("reset_go_fin", 32'({go, finish}), 32'd0);
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
`ifdef RANGE_SEQ_LEN_OUT_EN
        chk("reset_frame_len", 32'(frame_len), 32'd0);
`endif

        // Table-driven section
        active = 0;
        mn = 0;
        mx = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clock); #1;
            s_if.in_valid = tbl[i].v;
            s_if.in_data  = tbl[i].d;
            s_if.in_last  = tbl[i].l;
            @(negedge clock);
            chk($sformatf("row%0d_ready", i), 32'(s_if.in_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d_go", i), 32'(go), 32'(tbl[i].go));
            chk($sformatf("row%0d_finish", i), 32'(finish), 32'(tbl[i].fin));
            chk($sformatf("row%0d_data", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_overflow", i), 32'(overflow), 32'd0);
            if (tbl[i].go) begin
                active = 1;
                mn = int'(data_out);
                mx = int'(data_out);
            end else if (active != 0) begin
                if (int'(data_out) < mn) mn = int'(data_out);
                if (int'(data_out) > mx) mx = int'(data_out);
            end
            if (tbl[i].fin) begin
                chk($sformatf("row%0d_range", i), 32'(mx - mn), 32'(tbl[i].rng));
                active = 0;
            end
        end

        // Overflow: 18 beats, last on the 18th
        mon_en  = 1;
        go_seen = 0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clock); #1;
            s_if.in_valid = 1'b1;
            s_if.in_data  = 8'(100 + i);
            s_if.in_last  = 1'b0;
            @(negedge clock);
            chk($sformatf("ovf_beat%0d_pulse", i), 32'(overflow), 32'd0);
        end
        @(posedge clock); #1;
        s_if.in_data = 8'd117;
        s_if.in_last = 1'b1;
        @(negedge clock);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_drop_ready", 32'(s_if.in_ready), 32'd1);
        chk("ovf_drop_busy", 32'(busy), 32'd1);
        @(posedge clock); #1;
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        @(negedge clock);
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
        chk("ovf_after_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        chk("ovf_no_go", 32'(go_seen), 32'd0);
        mon_en = 0;
        frm[0] = 8'd1;
        frm[1] = 8'd4;
        frame_check(2, 3, "post_ovf");

        // Reset in the middle of an 8-sample burst
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            s_if.in_valid = 1'b1;
            s_if.in_data  = 8'(10 * (i + 1));
            s_if.in_last  = (i == 7);
        end
        @(posedge clock); #1;
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_data", 32'(data_out), 32'd20);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_go_fin", 32'({go, finish}), 32'd0);
        chk("rst_mid_data", 32'(data_out), 32'd0);
        chk("rst_mid_ready", 32'(s_if.in_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        frm[0] = 8'd7;
        frm[1] = 8'd3;
        frm[2] = 8'd11;
        frame_check(3, 8, "post_rst");
`ifdef RANGE_SEQ_LEN_OUT_EN
        chk("frame_len", 32'(frame_len), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_range_frame_sequencer
